// File: rtl/seq_divider_if.sv
// seq_divider_if: start/operand/result bundle for the sequential divider
//   master : drives start, A, B; observes Q, R, busy, done, div_by_zero
//   slave  : the divider side of the same signals
interface seq_divider_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] R;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    modport master (
        output start, A, B,
        input  Q, R, busy, done, div_by_zero
    );
    modport slave (
        input  start, A, B,
        output Q, R, busy, done, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, Q = A / B, R = A % B
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of seq_divider_if
//           start/A/B in; Q/R/div_by_zero registered results;
//           busy while iterating; done pulses one cycle per completion
module seq_divider #(
    parameter int WIDTH = 4
) (
    input logic         clk,
    input logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] qs_q, qs_d;
    logic [WIDTH-1:0] dv_q, dv_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   shifted, diff, p_next;
    logic [WIDTH-1:0] qs_next;
    logic             borrow;
    logic             unused_bits;

    // P never exceeds DV-1, so its top bit and the bit shifted out of QS are always zero
    assign unused_bits = p_q[WIDTH] ^ qs_q[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            d_q     <= '0;
            qs_q    <= '0;
            dv_q    <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            d_q     <= d_d;
            qs_q    <= qs_d;
            dv_q    <= dv_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        d_d     = d_q;
        qs_d    = qs_q;
        dv_d    = dv_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        shifted = {p_q[WIDTH-1:0], d_q[WIDTH-1]};
        diff    = shifted - {1'b0, dv_q};
        borrow  = diff[WIDTH];
        p_next  = borrow ? shifted : diff;
        qs_next = {qs_q[WIDTH-2:0], ~borrow};
        unique case (state_q)
            CALC: begin
                if (dv_q == '0) begin
                    // D has not shifted yet, so it still holds the dividend
                    q_d     = '1;
                    r_d     = d_q;
                    dbz_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    p_d   = p_next;
                    qs_d  = qs_next;
                    d_d   = {d_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        q_d     = qs_next;
                        r_d     = p_next[WIDTH-1:0];
                        dbz_d   = 1'b0;
                        state_d = FIN;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = state_q;
        endcase
        // a new request in FIN overlaps the done cycle, giving back-to-back operation
        if (bus.start && state_q != CALC) begin
            state_d = CALC;
            p_d     = '0;
            d_d     = bus.A;
            dv_d    = bus.B;
            qs_d    = '0;
            cnt_d   = '0;
        end
    end

    assign bus.Q           = q_q;
    assign bus.R           = r_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.busy        = state_q == CALC;
    assign bus.done        = state_q == FIN;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed-vector and corner-sequence bench for seq_divider (WIDTH=4)
module tb_seq_divider;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    seq_divider_if #(.WIDTH(W)) bus ();
    seq_divider #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", int'(bus.done), 1);
    endtask

    initial begin
        int n;
        int extra;
        logic [W-1:0] ra, rb, eq, er;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        vecs[0] = '{4'd13, 4'd3,  4'd4,  4'd1, 1'b0, 4};
        vecs[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 4};
        vecs[2] = '{4'd5,  4'd7,  4'd0,  4'd5, 1'b0, 4};
        vecs[3] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 4};
        vecs[4] = '{4'd0,  4'd9,  4'd0,  4'd0, 1'b0, 4};
        vecs[5] = '{4'd9,  4'd0,  4'd15, 4'd9, 1'b1, 1};
        vecs[6] = '{4'd8,  4'd2,  4'd4,  4'd0, 1'b0, 4};
        vecs[7] = '{4'd12, 4'd5,  4'd2,  4'd2, 1'b0, 4};
        vecs[8] = '{4'd7,  4'd2,  4'd3,  4'd1, 1'b0, 4};
        vecs[9] = '{4'd1,  4'd15, 4'd0,  4'd1, 1'b0, 4};

        repeat (2) @(negedge clk);
        check("rst_Q", int'(bus.Q), 0);
        check("rst_R", int'(bus.R), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_dbz", int'(bus.div_by_zero), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_busy", i), int'(bus.busy), 1);
            wait_done(n);
            check($sformatf("vec%0d_Q", i), int'(bus.Q), int'(vecs[i].q));
            check($sformatf("vec%0d_R", i), int'(bus.R), int'(vecs[i].r));
            check($sformatf("vec%0d_dbz", i), int'(bus.div_by_zero), int'(vecs[i].z));
            check($sformatf("vec%0d_lat", i), n, vecs[i].lat);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), int'(bus.done), 0);
            check($sformatf("vec%0d_idle", i), int'(bus.busy), 0);
        end

        // start held high through CALC with changed operands must be ignored
        bus.start = 1'b1;
        bus.A     = 4'd14;
        bus.B     = 4'd4;
        @(negedge clk);
        bus.A = 4'd5;
        bus.B = 4'd1;
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        wait_done(n);
        check("hold_lat", n, 2);
        check("hold_Q", int'(bus.Q), 3);
        check("hold_R", int'(bus.R), 2);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            extra += int'(bus.done);
        end
        check("hold_extra_done", extra, 0);

        // back-to-back: new start in the done cycle
        start_op(4'd14, 4'd4);
        wait_done(n);
        check("b2b_first_Q", int'(bus.Q), 3);
        check("b2b_first_R", int'(bus.R), 2);
        start_op(4'd10, 4'd3);
        check("b2b_no_gap_busy", int'(bus.busy), 1);
        check("b2b_hold_Q", int'(bus.Q), 3);
        check("b2b_hold_R", int'(bus.R), 2);
        wait_done(n);
        check("b2b_lat", n, 4);
        check("b2b_Q", int'(bus.Q), 3);
        check("b2b_R", int'(bus.R), 1);
        @(negedge clk);

        // asynchronous reset in the middle of an operation
        start_op(4'd13, 4'd3);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_Q", int'(bus.Q), 0);
        check("arst_R", int'(bus.R), 0);
        check("arst_busy", int'(bus.busy), 0);
        check("arst_done", int'(bus.done), 0);
        check("arst_dbz", int'(bus.div_by_zero), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            extra += int'(bus.done);
        end
        check("arst_no_done", extra, 0);
        check("arst_idle", int'(bus.busy), 0);
        start_op(4'd13, 4'd3);
        wait_done(n);
        check("arst_rerun_lat", n, 4);
        check("arst_rerun_Q", int'(bus.Q), 4);
        check("arst_rerun_R", int'(bus.R), 1);
        @(negedge clk);

        // random operands against a behavioural reference
        for (int i = 0; i < 500; i++) begin
            ra = W'($urandom_range(0, 15));
            rb = W'($urandom_range(0, 15));
            eq = (rb == 0) ? '1 : ra / rb;
            er = (rb == 0) ? ra : ra % rb;
            start_op(ra, rb);
            wait_done(n);
            check($sformatf("rnd%0d_Q(%0d/%0d)", i, ra, rb), int'(bus.Q), int'(eq));
            check($sformatf("rnd%0d_R(%0d/%0d)", i, ra, rb), int'(bus.R), int'(er));
            check($sformatf("rnd%0d_dbz", i), int'(bus.div_by_zero), int'(rb == 0));
            check($sformatf("rnd%0d_lat", i), n, (rb == 0) ? 1 : W);
            if (rb != 0)
                check($sformatf("rnd%0d_R_lt_B", i), int'(bus.R < rb), 1);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Multi-cycle unsigned restoring divider; the inverse of the team's combinational array multiplier (multi4bit).
- Accepts dividend A and divisor B on a start pulse.
- Produces quotient Q and remainder R after WIDTH iteration cycles, with a start/busy/done handshake.
- Sits alongside the multiplier in the arithmetic datapath; lets the control FSM undo or check products (A == Q*B + R).

Parameters:
WIDTH, 4, operand width in bits for A, B, Q and R; legal range 2..16.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on rising clk edge, accepted only when busy=0
A  input  WIDTH  dividend, unsigned, captured on the accepting edge
B  input  WIDTH  divisor, unsigned, captured on the accepting edge
Q  output  WIDTH  quotient, registered
R  output  WIDTH  remainder, registered
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse when Q/R/div_by_zero are updated
div_by_zero  output  1  registered flag for the most recent completed operation

Behaviour:
- Reset (rst_n low, asynchronous, at any time):
  - state=IDLE.
  - Q=0, R=0, busy=0, done=0, div_by_zero=0.
  - All internal registers cleared; any in-flight operation is aborted with no done pulse.
- States:
  - IDLE: busy=0.
  - CALC: busy=1.
  - FIN: busy=0, done=1 for exactly this one cycle.
- Accept rule:
  - start=1 at an edge while in IDLE or FIN loads the operands and enters CALC.
  - Also on that edge: busy=1, done=0, iteration counter=0.
  - In FIN the done pulse and the new acceptance coincide, so back-to-back operations are allowed.
  - start while in CALC is ignored; operands are not re-sampled.
- Internal registers:
  - Partial remainder P: WIDTH+1 bits, cleared on load.
  - Shift register D: holds the dividend, shifts out MSB first.
  - Quotient shift register QS: WIDTH bits.
  - Divisor register DV: WIDTH bits.
  - Counter: clog2(WIDTH)+1 bits.
- CALC iteration, one per edge, WIDTH edges total:
  - T = {P[WIDTH-1:0], D[MSB]} - {1'b0, DV}, computed in WIDTH+1 bits.
  - If T is non-negative (no borrow): P=T, shift 1 into QS LSB.
  - Otherwise: P={P[WIDTH-1:0], D[MSB]}, shift 0 into QS.
  - D shifts left by one.
- Completion:
  - On the edge performing iteration WIDTH: Q=final QS, R=P[WIDTH-1:0], div_by_zero=0; go to FIN.
- Latency: accept on edge k → done high during the cycle after edge k+WIDTH. Q/R are valid from that cycle.
- Divide by zero (DV=0 at the accepting edge):
  - The next edge skips iteration and goes to FIN.
  - Q=all ones, R=A, div_by_zero=1.
  - done is high in the cycle after edge k+1.
- Hold rule: Q, R and div_by_zero hold their values until the next completion or reset. An accept does not clear them.
- Without a new start, FIN returns to IDLE on the next edge.
- Arithmetic range: 0 ≤ R < B always holds for B≠0; no overflow is possible.

Test Plan:
- Reset, then 13/3, WIDTH=4: start pulse at edge 0 → busy=1 for edges 0..4, done=1 after edge 4, Q=4, R=1, div_by_zero=0.
- Sweep edge and boundary operands:
  - 15/1 → Q=15, R=0.
  - 5/7 → Q=0, R=5.
  - 15/15 → Q=1, R=0.
  - 0/9 → Q=0, R=0.
  - Each completes in exactly 4 iteration edges.
- 9/0 → done after 1 edge, Q=15, R=9, div_by_zero=1. Then 8/2 → Q=4, R=0, div_by_zero=0.
- Start held high while busy with different A/B (first op 14/4) → second request ignored; Q=3, R=2; no extra done pulse.
- start asserted in the done cycle of 14/4 with 10/3 → new op accepted with no idle gap; Q/R stay 3/2 until the second done, then become 3/1.
- rst_n low at edge 2 of 13/3 → Q=R=busy=done=0 immediately (asynchronous); no done pulse follows. After release, 13/3 runs correctly.
- Randomised 4-bit A/B, 500 ops, plus a WIDTH=8 build → A == Q*B + R and R < B whenever B≠0.
